// File: rtl/seq_det_pkg.sv
// Shared constants, types and helpers for the sequence-detector event logger.
package seq_det_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  // Pointer width for a power-of-2 FIFO: one extra bit distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);

  typedef logic [TS_W_DEF-1:0] ts_t;

endpackage

// File: rtl/ts_fifo.sv
// Parameterised synchronous FIFO with wrap-bit pointers and an unregistered head output.
// A push while full is ignored unless a pop happens in the same cycle.
module ts_fifo
  import seq_det_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty & ~i_clr;
  assign w_do_push = i_push & ~i_clr & (~o_full | w_do_pop);

  // Advance read/write pointers; clear returns both to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  // Head data straight from storage, forced to zero when nothing is queued.
  always_comb begin
    if (o_empty) o_data = '0;
    else         o_data = r_mem[r_rptr[AW-1:0]];
  end

endmodule

// File: rtl/seq_event_logger.sv
// Timestamps detection pulses into a FIFO drained over valid/ready, and keeps
// a saturating detection count plus a sticky overflow flag.
// Optional feature: define SEQ_LOG_DROP_CNT_EN to add the drop_count output.
module seq_event_logger
  import seq_det_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             detected,
  input  logic             clr,
  output logic             ts_valid,
  input  logic             ts_ready,
  output logic [TS_W-1:0]  ts_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
`ifdef SEQ_LOG_DROP_CNT_EN
  ,output logic [CNT_W-1:0] drop_count
`endif
);

  localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // Clear wins over both push and pop; a full FIFO accepts a push only alongside a pop.
  assign w_pop  = ~w_empty & ts_ready & ~clr;
  assign w_push = detected & ~clr & (~w_full | w_pop);
  assign w_drop = detected & ~clr & w_full & ~w_pop;

  ts_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_ts),
    .o_data  (ts_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ts_valid = ~w_empty;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

  // Free-running timestamp counter; wraps naturally at 2^TS_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_ts <= '0;
    else if (clr)  r_ts <= '0;
    else           r_ts <= r_ts + TS_ONE;
  end

  // Saturating total of all detections, dropped ones included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_count <= '0;
    else if (clr)                            r_count <= '0;
    else if (detected && (r_count != CNT_MAX)) r_count <= r_count + CNT_ONE;
    else                                     r_count <= r_count;
  end

  // Sticky flag recording that at least one timestamp was lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_overflow <= 1'b0;
    else if (clr)    r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
    else             r_overflow <= r_overflow;
  end

`ifdef SEQ_LOG_DROP_CNT_EN
  logic [CNT_W-1:0] r_drop_count;

  assign drop_count = r_drop_count;

  // Saturating count of timestamps lost to a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     r_drop_count <= '0;
    else if (clr)                                 r_drop_count <= '0;
    else if (w_drop && (r_drop_count != CNT_MAX)) r_drop_count <= r_drop_count + CNT_ONE;
    else                                          r_drop_count <= r_drop_count;
  end
`endif

endmodule

// File: tb/tb_seq_event_logger.sv
// Scoreboard bench for seq_event_logger (default build and SEQ_LOG_DROP_CNT_EN build).
module tb_seq_event_logger;
  import seq_det_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        detected = 1'b0;
  logic        clr = 1'b0;
  logic        ts_ready = 1'b0;
  logic        ts_valid;
  logic [15:0] ts_data;
  logic        full;
  logic        empty;
  logic [7:0]  count;
  logic        overflow;
`ifdef SEQ_LOG_DROP_CNT_EN
  logic [7:0]  drop_count;
  logic [7:0]  drop_count4;
`endif

  // Narrow-timestamp instance for the wrap scenario.
  logic        det4 = 1'b0;
  logic        clr4 = 1'b0;
  logic        rdy4 = 1'b0;
  logic        ts_valid4;
  logic [3:0]  ts_data4;
  logic        full4;
  logic        empty4;
  logic [7:0]  count4;
  logic        overflow4;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard state
  ts_t         m_ts;
  ts_t         exp_q[$];
  logic [16:0] got_q[$];
  logic [16:0] expd_q[$];
  int          e_cnt  = 0;
  int          e_drop = 0;
  logic        e_ovf  = 1'b0;

  always #5 clk = ~clk;

  seq_event_logger dut (
    .clk(clk), .rst(rst), .detected(detected), .clr(clr),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
`ifdef SEQ_LOG_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  seq_event_logger #(.TS_W(4)) dut4 (
    .clk(clk), .rst(rst), .detected(det4), .clr(clr4),
    .ts_valid(ts_valid4), .ts_ready(rdy4), .ts_data(ts_data4),
    .full(full4), .empty(empty4), .count(count4), .overflow(overflow4)
`ifdef SEQ_LOG_DROP_CNT_EN
    , .drop_count(drop_count4)
`endif
  );

  // Reference cycle counter for the main instance.
  always @(posedge clk or negedge rst) begin
    if (!rst)     m_ts <= 16'd0;
    else if (clr) m_ts <= 16'd0;
    else          m_ts <= m_ts + 16'd1;
  end

  // Drive one cycle and update the scoreboard; any pop records the observed head.
  task automatic drive(input logic det, input logic rdy, input logic c);
    logic pop_m;
    detected = det;
    ts_ready = rdy;
    clr      = c;
    pop_m = (exp_q.size() > 0) && rdy && !c;
    if (pop_m) begin
      got_q.push_back({ts_valid, ts_data});
      expd_q.push_back({1'b1, exp_q.pop_front()});
    end
    if (c) begin
      exp_q.delete();
      e_cnt  = 0;
      e_drop = 0;
      e_ovf  = 1'b0;
    end else if (det) begin
      if (e_cnt != 255) e_cnt++;
      if (exp_q.size() < 8) exp_q.push_back(m_ts);
      else begin
        e_ovf = 1'b1;
        if (e_drop != 255) e_drop++;
      end
    end
    @(posedge clk);
    #1;
    detected = 1'b0;
    ts_ready = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle_until(input ts_t target);
    for (int k = 0; k < 200 && m_ts != target; k++) drive(1'b0, 1'b0, 1'b0);
    if (m_ts != target) begin
      n_chk++; n_fail++;
      $display("FAIL idle_until: counter %0d, required %0d", m_ts, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_chk++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ts_valid); end
    n_chk++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_chk++; if (full !== 1'b0)     begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_chk++; if (ts_data !== 16'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", ts_data); end
    n_chk++; if (count !== 8'd0)    begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [16:0] g, x;
    idle_until(16'd5);
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (ts_valid !== 1'b1)  begin n_fail++; $display("FAIL single_valid: got %b want 1", ts_valid); end
    n_chk++; if (ts_data !== 16'd5)  begin n_fail++; $display("FAIL single_data: got %0d want 5", ts_data); end
    n_chk++; if (count !== 8'd1)     begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    drive(1'b0, 1'b1, 1'b0);
    n_chk++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL single_empty: got %b want 1", empty); end
    n_chk++; if (got_q.size() != 1)  begin n_fail++; $display("FAIL single_pops: got %0d want 1", got_q.size()); end
    while (got_q.size() > 0 && expd_q.size() > 0) begin
      g = got_q.pop_front(); x = expd_q.pop_front();
      n_chk++; if (g !== x) begin n_fail++; $display("FAIL single_pop: got %h want %h", g, x); end
    end
    // Pop attempt on an empty FIFO changes nothing.
    drive(1'b0, 1'b1, 1'b0);
    n_chk++; if (empty !== 1'b1 || ts_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop: empty %b valid %b want 1 0", empty, ts_valid); end
    n_chk++; if (full !== 1'b0)      begin n_fail++; $display("FAIL empty_pop_full: got %b want 0", full); end
  endtask

  task automatic test_fill_overflow();
    logic [16:0] g, x;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      idle_until(ts_t'(10 + 2 * i));
      drive(1'b1, 1'b0, 1'b0);
    end
    n_chk++; if (full !== 1'b1)      begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
    n_chk++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL fill_ovf: got %b want 0", overflow); end
    idle_until(16'd26);
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (overflow !== 1'b1)  begin n_fail++; $display("FAIL drop_ovf: got %b want 1", overflow); end
    n_chk++; if (count !== 8'(e_cnt)) begin n_fail++; $display("FAIL drop_count9: got %0d want %0d", count, e_cnt); end
    n_chk++; if (full !== 1'b1)      begin n_fail++; $display("FAIL drop_full: got %b want 1", full); end
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0);
    n_chk++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    n_chk++; if (got_q.size() != 8)  begin n_fail++; $display("FAIL drain_pops: got %0d want 8", got_q.size()); end
    for (int i = 0; got_q.size() > 0 && expd_q.size() > 0; i++) begin
      g = got_q.pop_front(); x = expd_q.pop_front();
      n_chk++; if (g !== x || g[15:0] !== 16'(10 + 2 * i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, g, x); end
    end
  endtask

  task automatic test_full_push_pop();
    logic [16:0] g, x;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0);
    idle_until(16'd40);
    drive(1'b1, 1'b1, 1'b0);
    n_chk++; if (full !== 1'b1)      begin n_fail++; $display("FAIL pp_full: got %b want 1", full); end
    n_chk++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL pp_ovf: got %b want 0", overflow); end
    n_chk++; if (count !== 8'd9)     begin n_fail++; $display("FAIL pp_count: got %0d want 9", count); end
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0);
    n_chk++; if (got_q.size() != 9)  begin n_fail++; $display("FAIL pp_pops: got %0d want 9", got_q.size()); end
    g = 17'd0;
    while (got_q.size() > 0 && expd_q.size() > 0) begin
      g = got_q.pop_front(); x = expd_q.pop_front();
      n_chk++; if (g !== x) begin n_fail++; $display("FAIL pp_data: got %h want %h", g, x); end
    end
    n_chk++; if (g[15:0] !== 16'd40) begin n_fail++; $display("FAIL pp_tail: got %0d want 40", g[15:0]); end
  endtask

  task automatic test_wrap();
    clr4 = 1'b1;
    @(posedge clk); #1;
    clr4 = 1'b0;
    for (int i = 0; i < 14; i++) begin @(posedge clk); #1; end
    det4 = 1'b1;
    @(posedge clk); #1;
    det4 = 1'b0;
    for (int i = 0; i < 2; i++) begin @(posedge clk); #1; end
    det4 = 1'b1;
    @(posedge clk); #1;
    det4 = 1'b0;
    n_chk++; if (ts_valid4 !== 1'b1 || ts_data4 !== 4'd14) begin n_fail++; $display("FAIL wrap_first: valid %b data %0d want 1 14", ts_valid4, ts_data4); end
    rdy4 = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (ts_valid4 !== 1'b1 || ts_data4 !== 4'd1)  begin n_fail++; $display("FAIL wrap_second: valid %b data %0d want 1 1", ts_valid4, ts_data4); end
    @(posedge clk); #1;
    rdy4 = 1'b0;
    n_chk++; if (empty4 !== 1'b1)  begin n_fail++; $display("FAIL wrap_empty: got %b want 1", empty4); end
  endtask

  task automatic test_saturate_clr();
    logic [16:0] g, x;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 1'b0);
    n_chk++; if (count !== 8'd255)   begin n_fail++; $display("FAIL sat_count: got %0d want 255", count); end
    n_chk++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL sat_ovf: got %b want 0", overflow); end
    drive(1'b0, 1'b1, 1'b0);
    n_chk++; if (got_q.size() != 300) begin n_fail++; $display("FAIL sat_pops: got %0d want 300", got_q.size()); end
    while (got_q.size() > 0 && expd_q.size() > 0) begin
      g = got_q.pop_front(); x = expd_q.pop_front();
      n_chk++; if (g !== x) begin n_fail++; $display("FAIL sat_data: got %h want %h", g, x); end
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    n_chk++; if (count !== 8'd0)     begin n_fail++; $display("FAIL clr_count: got %0d want 0", count); end
    n_chk++; if (empty !== 1'b1 || ts_valid !== 1'b0) begin n_fail++; $display("FAIL clr_empty: empty %b valid %b want 1 0", empty, ts_valid); end
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (ts_valid !== 1'b1 || ts_data !== 16'd0) begin n_fail++; $display("FAIL clr_ts: valid %b data %0d want 1 0", ts_valid, ts_data); end
    n_chk++; if (count !== 8'd1)     begin n_fail++; $display("FAIL clr_recount: got %0d want 1", count); end
  endtask

  task automatic test_drop_reset();
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (overflow !== e_ovf) begin n_fail++; $display("FAIL drop3_ovf: got %b want %b", overflow, e_ovf); end
    n_chk++; if (count !== 8'd11)    begin n_fail++; $display("FAIL drop3_count: got %0d want 11", count); end
`ifdef SEQ_LOG_DROP_CNT_EN
    n_chk++; if (drop_count !== 8'(e_drop)) begin n_fail++; $display("FAIL drop3_dcnt: got %0d want %0d", drop_count, e_drop); end
`endif
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete(); e_cnt = 0; e_drop = 0; e_ovf = 1'b0;
    n_chk++; if (ts_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: valid %b empty %b full %b want 0 1 0", ts_valid, empty, full); end
    n_chk++; if (count !== 8'd0 || overflow !== 1'b0 || ts_data !== 16'd0) begin n_fail++; $display("FAIL midrst_state: count %0d ovf %b data %0d want 0 0 0", count, overflow, ts_data); end
`ifdef SEQ_LOG_DROP_CNT_EN
    n_chk++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL midrst_dcnt: got %0d want 0", drop_count); end
`endif
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_saturate_clr();
    test_drop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_event_logger.md
Name: seq_event_logger

Overview:
- Downstream consumer of the 1010 sequence detector's `detected` output.
- Timestamps every detection pulse against a free-running cycle counter and buffers the timestamps in a small FIFO.
- Software or a downstream stage drains the FIFO over a valid/ready handshake.
- Also keeps a saturating total-detection count and a sticky overflow flag.

Parameters:
- TS_W, 16, timestamp counter width in bits.
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 8, total-detection counter width in bits.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- detected  input  1  one-cycle detection pulse from the sequence detector, sampled on posedge clk.
- clr  input  1  synchronous clear of all state.
- ts_valid  output  1  FIFO head holds a timestamp.
- ts_ready  input  1  consumer accepts the head this cycle.
- ts_data  output  TS_W  timestamp at the FIFO head.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  CNT_W  total detections seen, saturating.
- overflow  output  1  sticky; set when a timestamp was dropped.

Behaviour:
- Reset (rst=0, asynchronous): timestamp counter=0, FIFO pointers=0, count=0, overflow=0. Outputs: ts_valid=0, empty=1, full=0, ts_data=0.
- Timestamp counter: increments by 1 every cycle and wraps from 2^TS_W-1 to 0.
- Push: on a posedge with detected=1, the counter value present before that edge's increment is written to the FIFO.
- Pop: occurs when ts_valid && ts_ready at a posedge. ts_data is driven from FIFO storage indexed by the read pointer, with no extra register stage.
- Latency: a push into an empty FIFO raises ts_valid in the next cycle. A pop and a push to the same empty FIFO cannot coincide, because ts_valid is 0 when empty.
- Pointers: read and write pointers are log2(DEPTH)+1 bits and wrap naturally.
  - empty = pointers equal.
  - full = MSBs differ and the remaining bits are equal.
- Full, push, no pop: the timestamp is dropped, overflow is set to 1, and FIFO contents are unchanged.
- Full, push and pop in the same cycle: the head is removed and the new entry is written. Nothing is dropped, overflow is unchanged and the FIFO stays full.
- Pop with ts_ready=1 while empty: no effect; the pointers do not move.
- count: increments on every detected=1, including dropped pushes, and holds at 2^CNT_W-1.
- overflow: stays 1 until clr or reset.
- clr=1: on the next posedge, pointers, count, overflow and the timestamp counter all return to 0. clr takes priority over detected and pop in the same cycle, so no push and no pop occur.
- ts_data while empty is don't-care. The verification bench checks ts_data only when ts_valid=1.
- Reset asserted mid-operation: all state clears immediately. The FIFO contents are discarded and are not required to be zeroed.

Optional Feature:
- Macro: SEQ_LOG_DROP_CNT_EN.
- With the macro defined: adds output port drop_count, CNT_W bits, reset to 0. It increments on every dropped push, saturates at 2^CNT_W-1, and is cleared by clr. overflow is still driven.
- Without the macro: the drop_count port and its logic are absent. Only the overflow flag reports drops.

Decomposition:
- Package seq_det_pkg holds:
  - default constants TS_W_DEF=16, DEPTH_DEF=8, CNT_W_DEF=8;
  - a localparam helper for the pointer width, log2(DEPTH)+1;
  - a typedef ts_t for the TS_W-bit timestamp.
- One sub-module, ts_fifo: a parameterised synchronous FIFO with push/pop, full/empty outputs and a head-data output.
- seq_event_logger instantiates ts_fifo and holds the timestamp counter, count, overflow and drop logic.

Test Plan:
- Reset, then a single detected pulse at timestamp 5 → ts_valid=1 on the next cycle, ts_data=5, count=1. Pop with ts_ready=1 → empty=1.
- 8 pulses with ts_ready=0 at timestamps 10,12,…,24 → full=1. A 9th pulse at timestamp 26 → overflow=1 and count=9. Draining returns exactly 10,12,…,24 in order.
- FIFO full, detected=1 and ts_ready=1 in the same cycle at timestamp 40 → head popped, 40 written at the tail, full stays 1, overflow stays 0.
- TS_W=4, pulses at counter values 14 and then 1 (after the wrap) → ts_data sequence 14, 1.
- CNT_W=8, 300 pulses while draining continuously → count=255, overflow=0. Then clr=1 together with detected=1 → count=0, empty=1, timestamp counter=0, nothing pushed.
- With SEQ_LOG_DROP_CNT_EN defined, fill to full and apply 3 more pulses with ts_ready=0 → drop_count=3, overflow=1. Then assert rst=0 mid-cycle → all outputs 0 and empty=1 before the next clock edge.
